uart_matmul_frame_ctrl: RTL
===========================

Name: uart_matmul_frame_ctrl

Overview:
Host-side protocol controller that sits directly downstream of the UART two-way link. It consumes received bytes (rx_data/rx_ready) and frames them into matrix A and B element writes for the multiplier core. It then starts the multiplication and waits for completion. Finally it reads back the result matrix and serialises it MSB-first into the link's transmit handshake (tx_start/tx_data/tx_busy).

Parameters:
N, 4, matrix dimension (N x N); legal 2..16
DATA_W, 8, A/B element width; fixed at 8 (one UART byte per element)
RES_W, 16, result element width; multiple of 8, 8..32
AW (localparam), clog2(N*N), element address width

Ports:
clk  in  1  system clock, all logic on rising edge
reset  in  1  synchronous, active-high reset
rx_data  in  8  received byte from UART link
rx_ready  in  1  RX byte valid; level or pulse, controller acts on its rising edge only
tx_data  out  8  byte to transmit
tx_start  out  1  one-cycle transmit request
tx_busy  in  1  UART TX busy
wr_en  out  1  one-cycle element write strobe to operand buffers
wr_sel  out  1  0 = matrix A, 1 = matrix B
wr_addr  out  AW  row-major element index
wr_data  out  DATA_W  element value
mm_start  out  1  one-cycle start pulse to multiplier
mm_done  in  1  multiplier completion (level or pulse, sampled high)
res_addr  out  AW  result read index
res_data  in  RES_W  result element, valid 1 cycle after res_addr
busy  out  1  high in every state except IDLE
rx_overrun  out  1  sticky: byte arrived while not loading; cleared by reset or accepted header

Behaviour:
- Reset values: all outputs 0, state IDLE, counters 0, rx_ready edge register 0.
- Byte event = rx_ready high this cycle and low the previous cycle. Exactly one event per byte.
- Frame format: header 0xA5, then N*N A bytes, then N*N B bytes, all row-major.
- IDLE: on an event with 0xA5, clear rx_overrun, clear idx, go to LOAD_A. Any other byte is ignored with no flag.
- LOAD_A: each event drives wr_en=1, wr_sel=0, wr_addr=idx, wr_data=rx_data in the next cycle (1-cycle latency). Then idx increments. After element N*N-1, idx=0 and go to LOAD_B.
- LOAD_B: same as LOAD_A with wr_sel=1. After the last element, go to START.
- START: mm_start=1 for exactly one cycle, then go to WAIT_DONE.
- WAIT_DONE: hold until mm_done=1, then idx=0 and go to RD_ADDR.
- RD_ADDR: res_addr=idx, then go to RD_LATCH. RD_LATCH: capture res_data into a shift register, set byte count = RES_W/8, go to SEND.
- SEND: wait for tx_busy=0. Then tx_data = top byte of the shift register, tx_start=1 for one cycle, go to WAIT_HI.
- WAIT_HI: wait for tx_busy=1 (tx_busy may rise 1+ cycles after tx_start; tx_start is not re-asserted). Go to WAIT_LO.
- WAIT_LO: wait for tx_busy=0. Shift the register left 8 and decrement the byte count.
  - Count remaining: go to SEND.
  - Count exhausted and idx<N*N-1: idx+1, go to RD_ADDR.
  - Otherwise: go to IDLE.
- Byte order: each element is sent MSB byte first; elements are sent row-major.
- Byte events in START..WAIT_LO set rx_overrun and are discarded. Data, idx and state are unaffected.
- idx never exceeds N*N-1; there is no wrap past the frame end.
- tx_start and wr_en are never high in the same cycle. mm_start fires once per frame.
- Reset mid-operation (any state): return to IDLE next cycle. No further wr_en, mm_start or tx_start pulses are issued. A partially loaded frame is abandoned; the host must resend the header.
- mm_done already high on entry to WAIT_DONE: exit on that first cycle.

Test Plan:
- N=2, RES_W=16. Send A5,01,02,03,04,05,06,07,08 -> wr pulses (sel,addr,data): (0,0,1)(0,1,2)(0,2,3)(0,3,4)(1,0,5)(1,1,6)(1,2,7)(1,3,8), then one mm_start pulse.
- Continue: model asserts mm_done with results 19,22,43,50. tx_busy model 10 cycles per byte -> TX bytes 00,13,00,16,00,2B,00,32, then busy=0.
- Send 3C,FF in IDLE, then A5 -> no writes, no overrun; loading starts at A5.
- Send a byte during WAIT_DONE -> rx_overrun=1, no wr_en, results unchanged. Next A5 clears the flag.
- Assert reset after 3 A bytes -> all outputs 0 next cycle. A fresh full frame then loads from addr 0 correctly.
- tx_busy rises 3 cycles after tx_start, and rx_ready is held high for 5 cycles per byte -> exactly one tx_start per byte, exactly one write per byte.

Source files
------------

// File: rtl/uart_matmul_frame_ctrl.sv
// rtl/uart_matmul_frame_ctrl.sv - UART frame controller feeding a matrix multiplier and returning its results
//
// Purpose: frames received bytes (header 0xA5, N*N A elements, N*N B elements)
// into operand writes, starts the multiplier, then reads back each result
// element and transmits it MSB byte first over the UART transmit handshake.
//
// Ports:
//   clk, reset            rising-edge clock, synchronous active-high reset
//   rx_data, rx_ready     received byte; acted on at rx_ready rising edge only
//   tx_data, tx_start     byte to send and its one-cycle request
//   tx_busy               transmitter busy
//   wr_en/sel/addr/data   one-cycle operand write (sel 0 = A, 1 = B)
//   mm_start, mm_done     multiplier start pulse and completion
//   res_addr, res_data    result read port (data valid one cycle after address)
//   busy                  high whenever not IDLE
//   rx_overrun            sticky: byte arrived while not loading
module uart_matmul_frame_ctrl #(
    parameter int N      = 4,
    parameter int DATA_W = 8,
    parameter int RES_W  = 16,
    localparam int AW    = $clog2(N * N)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [7:0]        rx_data,
    input  logic              rx_ready,
    output logic [7:0]        tx_data,
    output logic              tx_start,
    input  logic              tx_busy,
    output logic              wr_en,
    output logic              wr_sel,
    output logic [AW-1:0]     wr_addr,
    output logic [DATA_W-1:0] wr_data,
    output logic              mm_start,
    input  logic              mm_done,
    output logic [AW-1:0]     res_addr,
    input  logic [RES_W-1:0]  res_data,
    output logic              busy,
    output logic              rx_overrun
);
    localparam int NB = RES_W / 8;
    localparam int CW = $clog2(NB + 1);
    localparam logic [AW-1:0] LAST_IDX = AW'(N * N - 1);
    localparam logic [CW-1:0] NB_C     = CW'(NB);

    typedef enum logic [3:0] {
        S_IDLE, S_LOAD_A, S_LOAD_B, S_START, S_WAIT_DONE,
        S_RD_ADDR, S_RD_LATCH, S_SEND, S_WAIT_HI, S_WAIT_LO
    } state_t;

    state_t              state_q, state_d;
    logic                rx_prev_q, rx_prev_d;
    logic [AW-1:0]       idx_q, idx_d;
    logic [RES_W-1:0]    shift_q, shift_d;
    logic [CW-1:0]       cnt_q, cnt_d;
    logic [7:0]          tx_data_q, tx_data_d;
    logic                tx_start_q, tx_start_d;
    logic                wr_en_q, wr_en_d;
    logic                wr_sel_q, wr_sel_d;
    logic [AW-1:0]       wr_addr_q, wr_addr_d;
    logic [DATA_W-1:0]   wr_data_q, wr_data_d;
    logic                mm_start_q, mm_start_d;
    logic [AW-1:0]       res_addr_q, res_addr_d;
    logic                busy_q, busy_d;
    logic                overrun_q, overrun_d;
    logic                byte_ev;

    assign byte_ev = rx_ready & ~rx_prev_q;

    always_comb begin
        state_d    = state_q;
        rx_prev_d  = rx_ready;
        idx_d      = idx_q;
        shift_d    = shift_q;
        cnt_d      = cnt_q;
        tx_data_d  = tx_data_q;
        tx_start_d = 1'b0;
        wr_en_d    = 1'b0;
        wr_sel_d   = wr_sel_q;
        wr_addr_d  = wr_addr_q;
        wr_data_d  = wr_data_q;
        mm_start_d = 1'b0;
        res_addr_d = res_addr_q;
        overrun_d  = overrun_q;

        case (state_q)
            S_IDLE: begin
                if (byte_ev && rx_data == 8'hA5) begin
                    overrun_d = 1'b0;
                    idx_d     = '0;
                    state_d   = S_LOAD_A;
                end
            end
            S_LOAD_A, S_LOAD_B: begin
                if (byte_ev) begin
                    wr_en_d   = 1'b1;
                    wr_sel_d  = (state_q == S_LOAD_B);
                    wr_addr_d = idx_q;
                    wr_data_d = DATA_W'(rx_data);
                    if (idx_q == LAST_IDX) begin
                        idx_d   = '0;
                        state_d = (state_q == S_LOAD_A) ? S_LOAD_B : S_START;
                    end else begin
                        idx_d = idx_q + AW'(1);
                    end
                end
            end
            S_START: begin
                mm_start_d = 1'b1;
                state_d    = S_WAIT_DONE;
            end
            S_WAIT_DONE: begin
                if (mm_done) begin
                    idx_d      = '0;
                    res_addr_d = '0;
                    state_d    = S_RD_ADDR;
                end
            end
            // res_addr is already presented during RD_ADDR (set on the
            // transition in), so the synchronous result read lands in RD_LATCH.
            S_RD_ADDR:  state_d = S_RD_LATCH;
            S_RD_LATCH: begin
                shift_d = res_data;
                cnt_d   = NB_C;
                state_d = S_SEND;
            end
            S_SEND: begin
                if (!tx_busy) begin
                    tx_data_d  = shift_q[RES_W-1 -: 8];
                    tx_start_d = 1'b1;
                    state_d    = S_WAIT_HI;
                end
            end
            S_WAIT_HI: begin
                if (tx_busy) state_d = S_WAIT_LO;
            end
            S_WAIT_LO: begin
                if (!tx_busy) begin
                    shift_d = shift_q << 8;
                    cnt_d   = cnt_q - CW'(1);
                    if (cnt_q != CW'(1)) begin
                        state_d = S_SEND;
                    end else if (idx_q != LAST_IDX) begin
                        idx_d      = idx_q + AW'(1);
                        res_addr_d = idx_q + AW'(1);
                        state_d    = S_RD_ADDR;
                    end else begin
                        state_d = S_IDLE;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Bytes outside IDLE/LOAD are dropped but flagged.
        if (byte_ev && !(state_q inside {S_IDLE, S_LOAD_A, S_LOAD_B}))
            overrun_d = 1'b1;

        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= S_IDLE;
            rx_prev_q  <= 1'b0;
            idx_q      <= '0;
            shift_q    <= '0;
            cnt_q      <= '0;
            tx_data_q  <= '0;
            tx_start_q <= 1'b0;
            wr_en_q    <= 1'b0;
            wr_sel_q   <= 1'b0;
            wr_addr_q  <= '0;
            wr_data_q  <= '0;
            mm_start_q <= 1'b0;
            res_addr_q <= '0;
            busy_q     <= 1'b0;
            overrun_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            rx_prev_q  <= rx_prev_d;
            idx_q      <= idx_d;
            shift_q    <= shift_d;
            cnt_q      <= cnt_d;
            tx_data_q  <= tx_data_d;
            tx_start_q <= tx_start_d;
            wr_en_q    <= wr_en_d;
            wr_sel_q   <= wr_sel_d;
            wr_addr_q  <= wr_addr_d;
            wr_data_q  <= wr_data_d;
            mm_start_q <= mm_start_d;
            res_addr_q <= res_addr_d;
            busy_q     <= busy_d;
            overrun_q  <= overrun_d;
        end
    end

    assign tx_data    = tx_data_q;
    assign tx_start   = tx_start_q;
    assign wr_en      = wr_en_q;
    assign wr_sel     = wr_sel_q;
    assign wr_addr    = wr_addr_q;
    assign wr_data    = wr_data_q;
    assign mm_start   = mm_start_q;
    assign res_addr   = res_addr_q;
    assign busy       = busy_q;
    assign rx_overrun = overrun_q;
endmodule
